// File: rtl/bg_palette_sequencer.sv
// Frame-synchronous background palette sequencer: applies a requested 3-color palette at a
// frame boundary, instantly or (with BG_FADE_EN defined) as a stepped per-field fade.
module bg_palette_sequencer #(
    parameter int unsigned FADE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       cfgReq,
    input  logic [7:0] cfgInner,
    input  logic [7:0] cfgOuter,
    input  logic [7:0] cfgBracket,
    output logic       cfgReady,
    output logic [7:0] innerRGB,
    output logic [7:0] outerRGB,
    output logic [7:0] bracketRGB,
    output logic       busy,
    output logic       done
);

`ifdef BG_FADE_EN
    typedef enum logic [1:0] {StIdle, StWaitSof, StFade, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWaitSof, StDone} state_e;
`endif

    localparam logic [7:0] InnerRst   = 8'hAF;
    localparam logic [7:0] OuterRst   = 8'hFC;
    localparam logic [7:0] BracketRst = 8'hFF;

    state_e     state_q, state_d;
    logic [7:0] inner_q, inner_d;
    logic [7:0] outer_q, outer_d;
    logic [7:0] bracket_q, bracket_d;
    logic [7:0] inner_tgt_q, outer_tgt_q, bracket_tgt_q;
    logic       accept;

    assign accept = cfgReq && (state_q == StIdle);

`ifdef BG_FADE_EN
    localparam logic [7:0] LastFrame = 8'(FADE_FRAMES - 1);

    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       at_target;

    // Move a field one unit toward its target; never overshoots.
    function automatic logic [2:0] step3(input logic [2:0] cur, input logic [2:0] tgt);
        if (cur < tgt) return cur + 3'd1;
        if (cur > tgt) return cur - 3'd1;
        return cur;
    endfunction

    function automatic logic [1:0] step2(input logic [1:0] cur, input logic [1:0] tgt);
        if (cur < tgt) return cur + 2'd1;
        if (cur > tgt) return cur - 2'd1;
        return cur;
    endfunction

    function automatic logic [7:0] step_color(input logic [7:0] cur, input logic [7:0] tgt);
        return {step3(cur[7:5], tgt[7:5]), step3(cur[4:2], tgt[4:2]), step2(cur[1:0], tgt[1:0])};
    endfunction

    assign at_target = (inner_q == inner_tgt_q) && (outer_q == outer_tgt_q) &&
                       (bracket_q == bracket_tgt_q);
`endif

    always_comb begin
        state_d   = state_q;
        inner_d   = inner_q;
        outer_d   = outer_q;
        bracket_d = bracket_q;
`ifdef BG_FADE_EN
        frame_cnt_d = frame_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cfgReq) state_d = StWaitSof;
            end
            StWaitSof: begin
                if (startOfFrame) begin
`ifdef BG_FADE_EN
                    state_d     = StFade;
                    frame_cnt_d = '0;
`else
                    state_d   = StDone;
                    inner_d   = inner_tgt_q;
                    outer_d   = outer_tgt_q;
                    bracket_d = bracket_tgt_q;
`endif
                end
            end
`ifdef BG_FADE_EN
            StFade: begin
                if (at_target) state_d = StDone;
                if (startOfFrame) begin
                    if (frame_cnt_q == LastFrame) begin
                        frame_cnt_d = '0;
                        inner_d     = step_color(inner_q, inner_tgt_q);
                        outer_d     = step_color(outer_q, outer_tgt_q);
                        bracket_d   = step_color(bracket_q, bracket_tgt_q);
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= StIdle;
            inner_q       <= InnerRst;
            outer_q       <= OuterRst;
            bracket_q     <= BracketRst;
            inner_tgt_q   <= InnerRst;
            outer_tgt_q   <= OuterRst;
            bracket_tgt_q <= BracketRst;
`ifdef BG_FADE_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            inner_q   <= inner_d;
            outer_q   <= outer_d;
            bracket_q <= bracket_d;
`ifdef BG_FADE_EN
            frame_cnt_q <= frame_cnt_d;
`endif
            if (accept) begin
                inner_tgt_q   <= cfgInner;
                outer_tgt_q   <= cfgOuter;
                bracket_tgt_q <= cfgBracket;
            end
        end
    end

    assign cfgReady   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign innerRGB   = inner_q;
    assign outerRGB   = outer_q;
    assign bracketRGB = bracket_q;

endmodule

// File: tb/tb_bg_palette_sequencer.sv
// Directed scoreboard bench for bg_palette_sequencer; expectations follow BG_FADE_EN.
module tb_bg_palette_sequencer;

    localparam int unsigned FADE_FRAMES = 2;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       cfgReq;
    logic [7:0] cfgInner, cfgOuter, cfgBracket;
    logic       cfgReady;
    logic [7:0] innerRGB, outerRGB, bracketRGB;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  cur_i, cur_o, cur_b;

`ifdef BG_FADE_EN
    // Inner color after each step of an 8'hAF -> 8'h00 fade.
    logic [7:0] fade_tbl [5] = '{8'h8A, 8'h65, 8'h40, 8'h20, 8'h00};
`endif

    bg_palette_sequencer #(.FADE_FRAMES(FADE_FRAMES)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .cfgReq       (cfgReq),
        .cfgInner     (cfgInner),
        .cfgOuter     (cfgOuter),
        .cfgBracket   (cfgBracket),
        .cfgReady     (cfgReady),
        .innerRGB     (innerRGB),
        .outerRGB     (outerRGB),
        .bracketRGB   (bracketRGB),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_colors(input string tag, input logic [7:0] i, input logic [7:0] o,
                                input logic [7:0] b);
        check({tag, "_inner"}, innerRGB, i);
        check({tag, "_outer"}, outerRGB, o);
        check({tag, "_bracket"}, bracketRGB, b);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must react at once.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        cfgReq       = 1'b0;
        startOfFrame = 1'b0;
        resetN       = 1'b0;
        #1;
        check_colors(tag, 8'hAF, 8'hFC, 8'hFF);
        check({tag, "_ready"}, cfgReady, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        #3;
        resetN = 1'b1;
        exp_q.delete();
        cur_i = 8'hAF;
        cur_o = 8'hFC;
        cur_b = 8'hFF;
    endtask

    task automatic request(input string tag, input logic [7:0] i, input logic [7:0] o,
                           input logic [7:0] b);
        for (int n = 0; n < 50 && !cfgReady; n++) tick();
        check({tag, "_ready_before"}, cfgReady, 1);
        cfgReq     = 1'b1;
        cfgInner   = i;
        cfgOuter   = o;
        cfgBracket = b;
        tick();
        cfgReq = 1'b0;
        exp_q.push_back({i, o, b});
        check({tag, "_busy_after"}, busy, 1);
        check({tag, "_ready_after"}, cfgReady, 0);
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [23:0] e;
        check({tag, "_done"}, done, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_colors(tag, e[23:16], e[15:8], e[7:0]);
            cur_i = e[23:16];
            cur_o = e[15:8];
            cur_b = e[7:0];
        end
    endtask

    // Pulse startOfFrame every 4th cycle until done, then check done lasts one cycle.
    task automatic run_until_done(input string tag, input int max_cycles);
        bit seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                pop_check(tag);
            end else begin
                startOfFrame = (c % 4 == 0);
                tick();
                startOfFrame = 1'b0;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            tick();
            check({tag, "_done_single"}, done, 0);
            check({tag, "_ready_back"}, cfgReady, 1);
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        cfgReq       = 1'b0;
        cfgInner     = '0;
        cfgOuter     = '0;
        cfgBracket   = '0;
        cur_i        = 8'hAF;
        cur_o        = 8'hFC;
        cur_b        = 8'hFF;
        #12;
        resetN = 1'b1;

        mid_reset("reset");

`ifdef BG_FADE_EN
        // Inner fades AF -> 00 in 5 steps, one step every 2nd frame; others already at target.
        request("fade", 8'h00, 8'hFC, 8'hFF);
        sof();
        check("fade_entry_inner", innerRGB, 8'hAF);
        for (int k = 1; k <= 10; k++) begin
            sof();
            check($sformatf("fade_k%0d_inner", k), innerRGB,
                  (k < 2) ? 8'hAF : fade_tbl[k / 2 - 1]);
            check($sformatf("fade_k%0d_outer", k), outerRGB, 8'hFC);
            check($sformatf("fade_k%0d_bracket", k), bracketRGB, 8'hFF);
            if (k == 5) begin
                cfgReq     = 1'b1;
                cfgInner   = 8'h11;
                cfgOuter   = 8'h22;
                cfgBracket = 8'h33;
                check("busy_req_ready", cfgReady, 0);
                tick();
                cfgReq = 1'b0;
            end
            if (k < 10) repeat (3) tick();
        end
        check("fade_f1_done", done, 0);
        tick();
        pop_check("fade_f2");
        tick();
        check("fade_f3_done", done, 0);
        check("fade_f3_ready", cfgReady, 1);
`else
        // Instant switch at the frame boundary 10 cycles after accept.
        request("nofade", 8'h00, 8'h03, 8'hE0);
        repeat (9) tick();
        check_colors("nofade_hold", 8'hAF, 8'hFC, 8'hFF);
        sof();
        pop_check("nofade_s1");
        tick();
        check("nofade_s2_done", done, 0);
        check("nofade_s2_busy", busy, 0);
        check("nofade_s2_ready", cfgReady, 1);

        // Second request while waiting for a frame must be ignored.
        request("busyreq", 8'hA1, 8'hB2, 8'hC3);
        cfgReq     = 1'b1;
        cfgInner   = 8'h11;
        cfgOuter   = 8'h22;
        cfgBracket = 8'h33;
        for (int n = 0; n < 3; n++) begin
            check($sformatf("busyreq_ready%0d", n), cfgReady, 0);
            tick();
        end
        cfgReq = 1'b0;
        run_until_done("busyreq", 40);
`endif

        // Request accepted in the same cycle as a frame pulse: that pulse is not consumed.
        cfgReq       = 1'b1;
        startOfFrame = 1'b1;
        cfgInner     = 8'h12;
        cfgOuter     = 8'h34;
        cfgBracket   = 8'h56;
        tick();
        cfgReq       = 1'b0;
        startOfFrame = 1'b0;
        exp_q.push_back({8'h12, 8'h34, 8'h56});
        check("simul_busy", busy, 1);
        check_colors("simul_a1", cur_i, cur_o, cur_b);
        repeat (3) tick();
        check_colors("simul_a4", cur_i, cur_o, cur_b);
        run_until_done("simul", 400);

`ifdef BG_FADE_EN
        // Reset after 3 fade steps, then a fresh request from power-up colors.
        mid_reset("pre_midfade");
        request("midfade", 8'h00, 8'hFC, 8'hFF);
        sof();
        for (int k = 0; k < 6; k++) begin
            sof();
            repeat (2) tick();
        end
        check("midfade_3steps_inner", innerRGB, 8'h40);
        mid_reset("midfade_reset");
`else
        request("midop", 8'h44, 8'h55, 8'h66);
        repeat (3) tick();
        mid_reset("midop_reset");
`endif
        request("fresh", 8'h00, 8'h03, 8'hE0);
        run_until_done("fresh", 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
